// File: rtl/my_arbiter_16_4_way.sv
// Round-robin arbiter feeding four 16-bit sources through a 4-way mux into a
// single-entry valid/ready output stage. A burst counter can keep one owner.

// Plain 4-way word mux driven by the arbiter select.
module my_arbiter_16_4_way_mux #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  // Select one of the four source words.
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

module my_arbiter_16_4_way #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BURST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 4;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] own;
  logic [CNT_W-1:0] cnt;

  logic [PTR_W-1:0] ptr_eff;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] idx;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;
  logic             slot_free;
  logic             any_req;
  logic             locked;
  logic             brk;
  logic             burst_end;
  logic [WIDTH-1:0] mux_out;

  // Winner selection: a live burst keeps its owner; otherwise search from the
  // (possibly break-advanced) pointer. The reverse loop lets the nearest
  // requester in search order overwrite the farther ones.
  always_comb begin
    slot_free = !out_valid || out_ready;
    any_req   = |req;
    locked    = (cnt != '0) && req[own];
    brk       = (cnt != '0) && !req[own];
    ptr_eff   = brk ? PTR_W'(own + PTR_W'(1)) : ptr;
    winner    = ptr_eff;
    idx       = '0;
    if (locked) begin
      winner = own;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        idx = PTR_W'(ptr_eff + PTR_W'(i));
        if (req[idx]) winner = idx;
      end
    end
    sel = any_req ? winner : ptr;
    ack = '0;
    if (slot_free && any_req && reset_n) ack[winner] = 1'b1;
    cnt_base  = locked ? cnt : '0;
    cnt_inc   = CNT_W'(cnt_base + CNT_W'(1));
    burst_end = (cnt_inc == CNT_W'(BURST));
  end

  my_arbiter_16_4_way_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (sel),
    .d0  (a),
    .d1  (b),
    .d2  (c),
    .d3  (d),
    .y   (mux_out)
  );

  // Output stage and arbitration state; everything holds under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
      own       <= '0;
      cnt       <= '0;
    end else if (slot_free) begin
      if (any_req) begin
        out       <= mux_out;
        out_valid <= 1'b1;
        own       <= winner;
        if (burst_end) begin
          cnt <= '0;
          ptr <= PTR_W'(winner + PTR_W'(1));
        end else begin
          cnt <= cnt_inc;
          ptr <= ptr_eff;
        end
      end else begin
        out_valid <= 1'b0;
        cnt       <= '0;
        ptr       <= ptr_eff;
      end
    end
  end

endmodule

// File: tb/tb_my_arbiter_16_4_way.sv
// Scoreboard bench: u1 runs BURST=1, u2 runs BURST=2 on shared stimulus;
// `focus` picks which instance the checks look at.
module tb_my_arbiter_16_4_way;

  localparam int unsigned WIDTH = 16;

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic [3:0]       req       = 4'b0000;
  logic [WIDTH-1:0] a         = 16'h8000;
  logic [WIDTH-1:0] b         = 16'h0800;
  logic [WIDTH-1:0] c         = 16'h0080;
  logic [WIDTH-1:0] d         = 16'h0008;
  logic             out_ready = 1'b1;

  logic [3:0]       ack1, ack2;
  logic [1:0]       sel1, sel2;
  logic [WIDTH-1:0] out1, out2;
  logic             out_valid1, out_valid2;

  int total = 0;
  int bad   = 0;
  int focus = 1;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  my_arbiter_16_4_way #(.WIDTH(WIDTH), .BURST(1)) u1 (
    .clk(clk), .reset_n(reset_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .ack(ack1), .sel(sel1), .out(out1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  my_arbiter_16_4_way #(.WIDTH(WIDTH), .BURST(2)) u2 (
    .clk(clk), .reset_n(reset_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .ack(ack2), .sel(sel2), .out(out2), .out_valid(out_valid2), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [WIDTH-1:0] word_of(input logic [3:0] oh);
    case (oh)
      4'b0001: return a;
      4'b0010: return b;
      4'b0100: return c;
      4'b1000: return d;
      default: return '0;
    endcase
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Consumer side: every word taken on an edge must match the next expected one.
  always @(negedge clk) begin : monitor
    logic             v;
    logic [WIDTH-1:0] o;
    v = (focus == 1) ? out_valid1 : out_valid2;
    o = (focus == 1) ? out1 : out2;
    if (v && out_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check("sb_out", 32'(o), 32'(exp_q.pop_front()));
    end
  end

  // One clock of stimulus; an expected grant pushes that source's word.
  task automatic cyc(input string tag, input logic [3:0] r, input logic rdy,
                     input logic [3:0] eack);
    req       = r;
    out_ready = rdy;
    if (eack != 4'b0000) exp_q.push_back(word_of(eack));
    @(negedge clk);
    check({tag, "_ack"}, 32'((focus == 1) ? ack1 : ack2), 32'(eack));
    if (eack != 4'b0000)
      check({tag, "_sel"}, 32'((focus == 1) ? sel1 : sel2), 32'(enc(eack)));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: time %0t exceeded", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset with all sources requesting.
    focus     = 1;
    req       = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",   32'(out1),       32'h0);
    check("rst_valid", 32'(out_valid1), 32'h0);
    check("rst_ack1",  32'(ack1),       32'h0);
    check("rst_ack2",  32'(ack2),       32'h0);
    check("rst_sel",   32'(sel1),       32'h0);
    reset_n = 1'b1;

    // Round robin, BURST=1.
    cyc("rr0", 4'b1111, 1'b1, 4'b0001);
    cyc("rr1", 4'b1111, 1'b1, 4'b0010);
    cyc("rr2", 4'b1111, 1'b1, 4'b0100);
    cyc("rr3", 4'b1111, 1'b1, 4'b1000);
    cyc("rr4", 4'b1111, 1'b1, 4'b0001);
    cyc("idle", 4'b0000, 1'b1, 4'b0000);
    cyc("idle", 4'b0000, 1'b1, 4'b0000);

    // Single source.
    cyc("single", 4'b0010, 1'b1, 4'b0010);
    check("single_out",   32'(out1),       32'h0800);
    check("single_valid", 32'(out_valid1), 32'h1);
    cyc("idle", 4'b0000, 1'b1, 4'b0000);
    check("idle_valid", 32'(out_valid1), 32'h0);

    // Backpressure: load c, stall five cycles, release grants d.
    cyc("bp_load", 4'b1111, 1'b1, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      cyc("bp_hold", 4'b1111, 1'b0, 4'b0000);
      check("bp_out",   32'(out1),       32'h0080);
      check("bp_valid", 32'(out_valid1), 32'h1);
    end
    cyc("bp_release", 4'b1111, 1'b1, 4'b1000);
    cyc("idle", 4'b0000, 1'b1, 4'b0000);
    cyc("idle", 4'b0000, 1'b1, 4'b0000);
    check("drain1", 32'(exp_q.size()), 32'd0);

    // Bursts of two, with a break on b and a wrap from d to a.
    focus = 2;
    do_reset();
    cyc("b0", 4'b1111, 1'b1, 4'b0001);
    cyc("b1", 4'b1111, 1'b1, 4'b0001);
    cyc("b2", 4'b1111, 1'b1, 4'b0010);
    cyc("b3_break", 4'b1101, 1'b1, 4'b0100);
    cyc("b4", 4'b1101, 1'b1, 4'b0100);
    cyc("b5", 4'b1111, 1'b1, 4'b1000);
    cyc("b6", 4'b1111, 1'b1, 4'b1000);
    cyc("b7_wrap", 4'b1111, 1'b1, 4'b0001);

    // Async reset mid-burst: a's word is discarded.
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", 32'(out_valid2), 32'h0);
    check("arst_out",   32'(out2),       32'h0);
    check("arst_ack",   32'(ack2),       32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("post_rst0", 4'b1111, 1'b1, 4'b0001);
    cyc("post_rst1", 4'b1111, 1'b1, 4'b0001);
    cyc("post_rst2", 4'b1111, 1'b1, 4'b0010);
    cyc("idle", 4'b0000, 1'b1, 4'b0000);
    cyc("idle", 4'b0000, 1'b1, 4'b0000);
    check("drain2", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
